// File: rtl/zelda_pkg.sv
// Shared types for the Link sprite path: direction encoding, ROM address
// width and the walk-animation state encoding.
package zelda_pkg;

  localparam int SPRITE_ADDR_W = 11;

  typedef enum logic [1:0] {
    DIR_DOWN  = 2'd0,
    DIR_UP    = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic {
    ANIM_STAND = 1'b0,
    ANIM_WALK  = 1'b1
  } anim_state_t;

endpackage

// File: rtl/link_anim_ctrl.sv
// Walk-animation controller. Advances only on the frame-start strobe so the
// selected walk frame is constant for a whole frame. The vsync that starts a
// walk counts as the first step, so with ANIM_PERIOD=N the frame toggles on
// the N-th, 2N-th, ... strobe of continuous walking.
module link_anim_ctrl
  import zelda_pkg::*;
#(
  parameter int ANIM_PERIOD = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic vsync_pulse,
  input  logic moving,
  output logic anim_frame
);

  localparam int CNT_W = (ANIM_PERIOD > 1) ? $clog2(ANIM_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ANIM_PERIOD - 1);

  anim_state_t      state;
  logic [CNT_W-1:0] cnt;

  // STAND/WALK state, step counter and frame bit, all moved only by vsync.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ANIM_STAND;
      cnt        <= '0;
      anim_frame <= 1'b0;
    end else if (vsync_pulse) begin
      case (state)
        ANIM_STAND: begin
          if (moving) begin
            state <= ANIM_WALK;
            if (cnt == CNT_LAST) begin
              cnt        <= '0;
              anim_frame <= ~anim_frame;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ANIM_WALK: begin
          if (!moving) begin
            state      <= ANIM_STAND;
            cnt        <= '0;
            anim_frame <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            cnt        <= '0;
            anim_frame <= ~anim_frame;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state      <= ANIM_STAND;
          cnt        <= '0;
          anim_frame <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/link_sprite_fetch.sv
// Per-pixel Link sprite fetch: frame-start latching of position/direction,
// 11-bit in-box test, ROM address formation and a fixed 3-cycle pipeline to
// the palette LUT (addr -> external ROM -> index/valid/opaque).
module link_sprite_fetch
  import zelda_pkg::*;
#(
  parameter int         SPRITE_W        = 16,
  parameter int         SPRITE_H        = 16,
  parameter int         ANIM_PERIOD     = 8,
  parameter logic [3:0] TRANSPARENT_IDX = 4'h0
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [9:0]               DrawX,
  input  logic [9:0]               DrawY,
  input  logic                     pix_active,
  input  logic                     vsync_pulse,
  input  logic [9:0]               link_x,
  input  logic [9:0]               link_y,
  input  logic [1:0]               link_dir,
  input  logic                     link_moving,
  output logic [SPRITE_ADDR_W-1:0] rom_addr,
  input  logic [3:0]               rom_data,
  output logic [3:0]               idx_out,
  output logic                     idx_valid,
  output logic                     opaque,
  output logic                     anim_frame
);

  logic [9:0] lx_q, ly_q;
  dir_t       dir_q;

  // Frame registers; pixels in the strobe cycle still see the old values.
  // The walking flag is sampled directly by the animation controller on the
  // same strobe, so it needs no separate copy here.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      lx_q  <= '0;
      ly_q  <= '0;
      dir_q <= DIR_DOWN;
    end else if (vsync_pulse) begin
      lx_q  <= link_x;
      ly_q  <= link_y;
      dir_q <= dir_t'(link_dir);
    end
  end

  link_anim_ctrl #(.ANIM_PERIOD(ANIM_PERIOD)) u_anim (
    .clk         (Clk),
    .reset       (Reset),
    .vsync_pulse (vsync_pulse),
    .moving      (link_moving),
    .anim_frame  (anim_frame)
  );

  // 11-bit compare so a box hanging past column/row 1023 never wraps to 0.
  logic [10:0] px, py, bx, by;
  logic        in_box;
  logic [3:0]  col, row;
  logic [SPRITE_ADDR_W-1:0] addr_nxt;

  assign px     = {1'b0, DrawX};
  assign py     = {1'b0, DrawY};
  assign bx     = {1'b0, lx_q};
  assign by     = {1'b0, ly_q};
  assign in_box = pix_active
                  && (px >= bx) && (px < bx + 11'(SPRITE_W))
                  && (py >= by) && (py < by + 11'(SPRITE_H));
  // Only the low nibble of the offset addresses the 16x16 image.
  assign col      = DrawX[3:0] - lx_q[3:0];
  assign row      = DrawY[3:0] - ly_q[3:0];
  assign addr_nxt = {dir_q, anim_frame, row, col};

  logic [2:1] vld_pipe;

  // Stage 1 address, stage 2 carry (ROM is busy), stage 3 index/flags.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rom_addr  <= '0;
      vld_pipe  <= '0;
      idx_out   <= '0;
      idx_valid <= 1'b0;
      opaque    <= 1'b0;
    end else begin
      rom_addr    <= addr_nxt;
      vld_pipe[1] <= in_box;
      vld_pipe[2] <= vld_pipe[1];
      idx_out     <= rom_data;
      idx_valid   <= vld_pipe[2];
      opaque      <= vld_pipe[2] && (rom_data != TRANSPARENT_IDX);
    end
  end

endmodule

// File: tb/tb_link_sprite_fetch.sv
// Directed bench for link_sprite_fetch. The sprite ROM is modelled with a
// one-cycle registered read whose data equals the column nibble of the
// address, so expected palette indices follow directly from the pixel.
module tb_link_sprite_fetch;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [9:0]  DrawX, DrawY, link_x, link_y;
  logic        pix_active, vsync_pulse, link_moving;
  logic [1:0]  link_dir;
  logic [10:0] rom_addr;
  logic [3:0]  rom_data, idx_out;
  logic        idx_valid, opaque, anim_frame;

  int errs   = 0;
  int checks = 0;

  link_sprite_fetch #(
    .SPRITE_W(16), .SPRITE_H(16), .ANIM_PERIOD(8), .TRANSPARENT_IDX(4'h0)
  ) dut (
    .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY),
    .pix_active(pix_active), .vsync_pulse(vsync_pulse),
    .link_x(link_x), .link_y(link_y), .link_dir(link_dir),
    .link_moving(link_moving), .rom_addr(rom_addr), .rom_data(rom_data),
    .idx_out(idx_out), .idx_valid(idx_valid), .opaque(opaque),
    .anim_frame(anim_frame)
  );

  always #5 Clk = ~Clk;

  // ROM model: data one cycle after address, content = column nibble.
  always @(posedge Clk) rom_data <= rom_addr[3:0];

  typedef struct {
    logic        vs;
    logic [9:0]  lx, ly;
    logic [1:0]  dir;
    logic        mv;
    logic [9:0]  x, y;
    logic        act;
    logic [10:0] addr;
    logic        v, op;
    logic [3:0]  idx;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(input logic vs, input int lx, input int ly,
                              input int dir, input int x, input int y,
                              input logic act, input int addr, input logic v,
                              input logic op, input int idx);
    vec_t r;
    r.vs = vs; r.lx = 10'(lx); r.ly = 10'(ly); r.dir = 2'(dir); r.mv = 1'b0;
    r.x = 10'(x); r.y = 10'(y); r.act = act; r.addr = 11'(addr);
    r.v = v; r.op = op; r.idx = 4'(idx);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic vsync(input int lx, input int ly, input int dir,
                       input logic mv);
    link_x = 10'(lx); link_y = 10'(ly); link_dir = 2'(dir);
    link_moving = mv; vsync_pulse = 1'b1;
    tick();
    vsync_pulse = 1'b0;
  endtask

  task automatic pixel(input int x, input int y, input logic act);
    DrawX = 10'(x); DrawY = 10'(y); pix_active = act;
  endtask

  initial begin
    // dir: 0 DOWN, 1 UP, 2 LEFT, 3 RIGHT; rom_addr = {dir,frame,row,col}
    tbl[0]  = mk(1, 100, 50, 1, 100, 50, 1, 'h200, 1, 0, 4'h0);
    tbl[1]  = mk(0, 100, 50, 1, 105, 50, 1, 'h205, 1, 1, 4'h5);
    tbl[2]  = mk(0, 100, 50, 1, 115, 65, 1, 'h2FF, 1, 1, 4'hF);
    tbl[3]  = mk(0, 100, 50, 1, 116, 65, 1, 'h2F0, 0, 0, 4'h0);
    tbl[4]  = mk(0, 100, 50, 1,  99, 50, 1, 'h20F, 0, 0, 4'h0);
    tbl[5]  = mk(0, 100, 50, 1, 110, 66, 1, 'h20A, 0, 0, 4'h0);
    tbl[6]  = mk(0, 100, 50, 1, 110, 49, 1, 'h2FA, 0, 0, 4'h0);
    tbl[7]  = mk(0, 100, 50, 1, 107, 60, 0, 'h2A7, 0, 0, 4'h0);
    tbl[8]  = mk(0, 100, 50, 1, 103, 62, 1, 'h2C3, 1, 1, 4'h3);
    tbl[9]  = mk(1, 1020, 50, 0,   0, 55, 1, 'h054, 0, 0, 4'h0);
    tbl[10] = mk(0, 1020, 50, 0,   3, 55, 1, 'h057, 0, 0, 4'h0);
    tbl[11] = mk(0, 1020, 50, 0, 1020, 55, 1, 'h050, 1, 0, 4'h0);
    tbl[12] = mk(0, 1020, 50, 0, 1023, 64, 1, 'h0E3, 1, 1, 4'h3);
    // link_x/link_y change without a strobe: latched box must not move
    tbl[13] = mk(0,    0,  0, 0, 1021, 55, 1, 'h051, 1, 1, 4'h1);
    tbl[14] = mk(0,    0,  0, 0,    0, 55, 1, 'h054, 0, 0, 4'h0);

    Reset = 1'b1; vsync_pulse = 1'b0; link_x = '0; link_y = '0;
    link_dir = '0; link_moving = 1'b0;
    pixel(0, 0, 0);
    tick(); tick();
    chk("rst_addr", rom_addr, 0);
    chk("rst_idx", idx_out, 0);
    chk("rst_valid", idx_valid, 0);
    chk("rst_opaque", opaque, 0);
    chk("rst_frame", anim_frame, 0);
    Reset = 1'b0;

    // latched defaults after reset: box at (0,0), dir DOWN
    pixel(3, 2, 1);
    tick(); chk("post_rst_addr", rom_addr, 'h023);
    tick(); tick(); chk("post_rst_valid", idx_valid, 1);

    for (int i = 0; i < 15; i++) begin
      if (tbl[i].vs) vsync(tbl[i].lx, tbl[i].ly, tbl[i].dir, tbl[i].mv);
      else begin
        link_x = tbl[i].lx; link_y = tbl[i].ly;
      end
      pixel(tbl[i].x, tbl[i].y, tbl[i].act);
      tick();
      chk($sformatf("v%0d_addr", i), rom_addr, tbl[i].addr);
      tick(); tick();
      chk($sformatf("v%0d_valid", i), idx_valid, tbl[i].v);
      chk($sformatf("v%0d_opaque", i), opaque, tbl[i].op);
      if (tbl[i].v) chk($sformatf("v%0d_idx", i), idx_out, tbl[i].idx);
    end

    // exact 3-cycle latency: one in-box pixel between out-of-box pixels
    vsync(100, 50, 1, 0);
    pixel(0, 0, 1);
    tick(); tick(); tick(); tick();
    pixel(100, 50, 1);
    tick(); chk("lat_addr", rom_addr, 'h200); chk("lat_v1", idx_valid, 0);
    pixel(0, 0, 1);
    tick(); chk("lat_v2", idx_valid, 0);
    tick(); chk("lat_v3", idx_valid, 1);
    tick(); chk("lat_v4", idx_valid, 0);

    // walk animation: toggles on the 8th, 16th, 24th strobe
    for (int k = 1; k <= 24; k++) begin
      vsync(100, 50, 2, 1);
      chk($sformatf("anim_%0d", k), anim_frame, 32'((k / 8) % 2));
    end
    vsync(100, 50, 3, 1);
    chk("anim_dirchg", anim_frame, 1);
    pixel(100, 50, 1);
    tick(); chk("anim_addr", rom_addr, 'h700);
    vsync(100, 50, 3, 0);
    chk("anim_stop", anim_frame, 0);

    // reset mid-line with in-box pixels in flight
    for (int k = 0; k < 8; k++) vsync(0, 0, 3, 1);
    chk("mr_frame_pre", anim_frame, 1);
    pixel(5, 5, 1);
    tick(); chk("mr_addr_pre", rom_addr, 'h755);
    tick(); tick(); chk("mr_valid_pre", idx_valid, 1);
    Reset = 1'b1;
    tick();
    chk("mr_valid", idx_valid, 0);
    chk("mr_opaque", opaque, 0);
    chk("mr_addr", rom_addr, 0);
    chk("mr_frame", anim_frame, 0);
    Reset = 1'b0;
    tick(); chk("mr_addr1", rom_addr, 'h055); chk("mr_v1", idx_valid, 0);
    tick(); chk("mr_v2", idx_valid, 0);
    tick(); chk("mr_v3", idx_valid, 1);
    chk("mr_idx3", idx_out, 5); chk("mr_op3", opaque, 1);

    // strobe coincident with reset: reset wins
    link_x = 10'd200; link_y = 10'd0; link_dir = 2'd1; link_moving = 1'b1;
    vsync_pulse = 1'b1; Reset = 1'b1;
    tick();
    vsync_pulse = 1'b0; Reset = 1'b0;
    tick();
    chk("co_addr", rom_addr, 'h055);
    chk("co_frame", anim_frame, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
